// File: rtl/ultra_sonic_pkg.sv
// Shared constants and state encoding for the ultrasonic driver and its echo emulator.
// Cycle counts assume a 50 MHz clock.
package ultra_sonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMWAIT   = 3'd1,
    ST_TRIG_HIGH = 3'd2,
    ST_BURST     = 3'd3,
    ST_ECHO      = 3'd4
  } echo_gen_state_t;

  localparam int CYCLES_PER_US          = 32'd50;
  localparam int TRIG_MIN_CYCLES_DEF    = 32'd10 * CYCLES_PER_US;
  localparam int BURST_DELAY_CYCLES_DEF = 32'd200 * CYCLES_PER_US;
  localparam int TIMEOUT_CYCLES_DEF     = 32'd38000 * CYCLES_PER_US;

endpackage

// File: rtl/ultra_sonic_echo_gen_sync_2ff.sv
// 1-bit two-flop synchronizer for the asynchronous trigger pin; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset_l,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ultra_sonic_echo_gen.sv
// Sensor-side emulation of the ultrasonic trigger/echo protocol: qualifies a trigger
// pulse, waits the burst delay, then drives echo for the programmed length.
module ultra_sonic_echo_gen
  import ultra_sonic_pkg::*;
#(
  parameter int COUNT_WIDTH        = 32'd32,
  parameter int TRIG_MIN_CYCLES    = TRIG_MIN_CYCLES_DEF,
  parameter int BURST_DELAY_CYCLES = BURST_DELAY_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [31:0] write_data,
  input  logic        write_valid,
  input  logic        trigger,
  output logic        echo,
  output logic        busy,
  output logic        trig_reject,
  output logic [15:0] pulse_count
);

  localparam int TW = $clog2(TRIG_MIN_CYCLES + 1);
  localparam int BW = $clog2(BURST_DELAY_CYCLES + 1);
  localparam logic [TW-1:0]          TRIG_MIN    = TW'(TRIG_MIN_CYCLES);
  localparam logic [BW-1:0]          BURST_LAST  = BW'(BURST_DELAY_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LEN = COUNT_WIDTH'(TIMEOUT_CYCLES);

  logic                   trig_s;
  logic                   trig_rise_s;
  logic [COUNT_WIDTH-1:0] echo_last_s;
  logic [COUNT_WIDTH-1:0] wr_len_s;

  echo_gen_state_t        state_q, state_d;
  logic                   trig_prev_q, trig_prev_d;
  logic [TW-1:0]          trig_cnt_q, trig_cnt_d;
  logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
  logic [COUNT_WIDTH-1:0] echo_cnt_q, echo_cnt_d;
  logic [COUNT_WIDTH-1:0] pending_q, pending_d;
  logic [COUNT_WIDTH-1:0] active_q, active_d;
  logic                   echo_q, echo_d;
  logic                   busy_q, busy_d;
  logic                   trig_reject_q, trig_reject_d;
  logic [15:0]            pulse_count_q, pulse_count_d;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_l (reset_l),
    .d       (trigger),
    .q       (trig_s)
  );

  assign trig_rise_s = trig_s & ~trig_prev_q;
  assign wr_len_s    = write_data[COUNT_WIDTH-1:0];
  // Last echo cycle index; a zero length means "no object" and uses the timeout width.
  assign echo_last_s = ((active_q == '0) ? TIMEOUT_LEN : active_q) - COUNT_WIDTH'(1);

  // Next-state, counter and length-register logic.
  always_comb begin
    state_d       = state_q;
    trig_prev_d   = trig_s;
    trig_cnt_d    = trig_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    echo_cnt_d    = echo_cnt_q;
    active_d      = active_q;
    pulse_count_d = pulse_count_q;
    trig_reject_d = 1'b0;
    if (write_valid) begin
      pending_d = wr_len_s;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (trig_rise_s) begin
          state_d    = ST_TRIG_HIGH;
          trig_cnt_d = TW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRIG_HIGH: begin
        if (trig_s) begin
          trig_cnt_d = (trig_cnt_q < TRIG_MIN) ? trig_cnt_q + TW'(1) : trig_cnt_q;
        end else if (trig_cnt_q >= TRIG_MIN) begin
          state_d     = ST_BURST;
          burst_cnt_d = '0;
          active_d    = write_valid ? wr_len_s : pending_q;
        end else begin
          state_d       = ST_IDLE;
          trig_reject_d = 1'b1;
        end
      end
      ST_BURST: begin
        if (burst_cnt_q == BURST_LAST) begin
          state_d    = ST_ECHO;
          echo_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + BW'(1);
        end
      end
      ST_ECHO: begin
        // A trigger still high here must be released before a new one can count.
        if (echo_cnt_q == echo_last_s) begin
          state_d       = trig_s ? ST_ARMWAIT : ST_IDLE;
          pulse_count_d = pulse_count_q + 16'd1;
        end else begin
          echo_cnt_d = echo_cnt_q + COUNT_WIDTH'(1);
        end
      end
      ST_ARMWAIT: begin
        if (!trig_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARMWAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_BURST) || (state_d == ST_ECHO);
    echo_d = (state_d == ST_ECHO);
  end

  // State, counters, length registers and registered outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= ST_IDLE;
      trig_prev_q   <= 1'b0;
      trig_cnt_q    <= '0;
      burst_cnt_q   <= '0;
      echo_cnt_q    <= '0;
      pending_q     <= '0;
      active_q      <= '0;
      echo_q        <= 1'b0;
      busy_q        <= 1'b0;
      trig_reject_q <= 1'b0;
      pulse_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      trig_prev_q   <= trig_prev_d;
      trig_cnt_q    <= trig_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      echo_cnt_q    <= echo_cnt_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      echo_q        <= echo_d;
      busy_q        <= busy_d;
      trig_reject_q <= trig_reject_d;
      pulse_count_q <= pulse_count_d;
    end
  end

  assign echo        = echo_q;
  assign busy        = busy_q;
  assign trig_reject = trig_reject_q;
  assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_ultra_sonic_echo_gen.sv
// Directed bench for ultra_sonic_echo_gen with a shortened burst delay and timeout.
module tb_ultra_sonic_echo_gen;

  localparam int BURST = 2000;
  localparam int TMO   = 200;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic        write_valid = 1'b0;
  logic        trigger = 1'b0;
  logic        echo;
  logic        busy;
  logic        trig_reject;
  logic [15:0] pulse_count;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int busy_rises = 0;
  int busy_rise_cyc = 0;
  int echo_rises = 0;
  int echo_falls = 0;
  int echo_rise_cyc = 0;
  int echo_width = 0;
  int reject_pulses = 0;
  int reject_cycles = 0;
  logic [15:0] pc_at_fall = 16'd0;
  logic busy_at_fall = 1'b0;
  logic echo_prev = 1'b0;
  logic busy_prev = 1'b0;
  logic rej_prev = 1'b0;

  always #5 clk = ~clk;

  ultra_sonic_echo_gen #(
    .BURST_DELAY_CYCLES (BURST),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .write_data  (write_data),
    .write_valid (write_valid),
    .trigger     (trigger),
    .echo        (echo),
    .busy        (busy),
    .trig_reject (trig_reject),
    .pulse_count (pulse_count)
  );

  // Edge and width observer, sampled on the falling clock edge.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    echo_prev <= echo;
    busy_prev <= busy;
    rej_prev  <= trig_reject;
    if (busy && !busy_prev) begin
      busy_rises    <= busy_rises + 1;
      busy_rise_cyc <= cyc;
    end
    if (echo && !echo_prev) begin
      echo_rises    <= echo_rises + 1;
      echo_rise_cyc <= cyc;
    end
    if (!echo && echo_prev) begin
      echo_falls   <= echo_falls + 1;
      echo_width   <= cyc - echo_rise_cyc;
      pc_at_fall   <= pulse_count;
      busy_at_fall <= busy;
    end
    if (trig_reject) reject_cycles <= reject_cycles + 1;
    if (trig_reject && !rej_prev) reject_pulses <= reject_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input int n);
    trigger = 1'b1;
    step(n);
    trigger = 1'b0;
  endtask

  task automatic write_len(input int v);
    write_data  = v;
    write_valid = 1'b1;
    step(1);
    write_valid = 1'b0;
  endtask

  task automatic wait_falls(input int target, input int budget);
    int k = 0;
    while (echo_falls < target && k < budget) begin
      step(1);
      k++;
    end
    step(2);
    check("echo_end_seen", {31'd0, echo_falls >= target}, 32'd1);
  endtask

  task automatic wait_rises(input int target, input int budget);
    int k = 0;
    while (echo_rises < target && k < budget) begin
      step(1);
      k++;
    end
    check("echo_rise_seen", {31'd0, echo_rises >= target}, 32'd1);
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_echo", {31'd0, echo}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_reject", {31'd0, trig_reject}, 32'd0);
    check("rst_count", {16'd0, pulse_count}, 32'd0);
    reset_l = 1'b1;
    step(2);

    // Nominal pulse at the minimum accepted trigger width
    write_len(1000);
    pulse(500);
    wait_falls(1, 5000);
    check("nom_gap", echo_rise_cyc - busy_rise_cyc, BURST);
    check("nom_width", echo_width, 32'd1000);
    check("nom_count", {16'd0, pulse_count}, 32'd1);
    check("nom_count_at_fall", {16'd0, pc_at_fall}, 32'd1);
    check("nom_busy_falls_with_echo", {31'd0, busy_at_fall}, 32'd0);
    check("nom_no_reject", reject_pulses, 32'd0);

    // Short trigger, one cycle below the minimum
    pulse(499);
    step(20000);
    check("short_reject_pulses", reject_pulses, 32'd1);
    check("short_reject_width", reject_cycles, 32'd1);
    check("short_no_busy", busy_rises, 32'd1);
    check("short_no_echo", echo_rises, 32'd1);

    // No object: zero length gives the timeout width
    write_len(0);
    pulse(500);
    wait_falls(2, 5000);
    check("tmo_width", echo_width, TMO);
    check("tmo_count", {16'd0, pulse_count}, 32'd2);

    // Write during ECHO affects only the next pulse
    write_len(1000);
    pulse(500);
    wait_rises(3, 5000);
    step(100);
    write_len(50);
    wait_falls(3, 5000);
    check("wr_echo_cur_width", echo_width, 32'd1000);
    pulse(500);
    wait_falls(4, 5000);
    check("wr_echo_next_width", echo_width, 32'd50);

    // Write in the acceptance cycle bypasses the pending register
    trigger = 1'b1;
    step(500);
    trigger = 1'b0;
    step(2);
    write_len(77);
    wait_falls(5, 5000);
    check("bypass_width", echo_width, 32'd77);
    check("bypass_count", {16'd0, pulse_count}, 32'd5);
    check("bypass_gap", echo_rise_cyc - busy_rise_cyc, BURST);

    // Trigger activity during BURST and ECHO is ignored
    write_len(300);
    pulse(500);
    step(100);
    pulse(600);
    wait_rises(6, 5000);
    step(10);
    pulse(100);
    wait_falls(6, 5000);
    step(3000);
    check("busy_trig_echoes", echo_rises, 32'd6);
    check("busy_trig_bursts", busy_rises, 32'd6);
    check("busy_trig_width", echo_width, 32'd300);

    // Trigger held across the echo end is never accepted
    pulse(500);
    wait_rises(7, 5000);
    trigger = 1'b1;
    wait_falls(7, 5000);
    step(100);
    trigger = 1'b0;
    step(3000);
    check("held_no_burst", busy_rises, 32'd7);
    check("held_no_reject", reject_pulses, 32'd1);
    pulse(500);
    wait_falls(8, 5000);
    check("held_next_burst", busy_rises, 32'd8);
    check("held_next_width", echo_width, 32'd300);
    check("held_next_count", {16'd0, pulse_count}, 32'd8);

    // Reset in the middle of a 1000-cycle echo
    write_len(1000);
    pulse(500);
    wait_rises(9, 5000);
    step(299);
    check("pre_reset_echo", {31'd0, echo}, 32'd1);
    reset_l = 1'b0;
    #1;
    check("mid_reset_echo", {31'd0, echo}, 32'd0);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_count", {16'd0, pulse_count}, 32'd0);
    step(3);
    reset_l = 1'b1;
    step(2);
    pulse(500);
    wait_falls(10, 5000);
    check("post_reset_width", echo_width, TMO);
    check("post_reset_count", {16'd0, pulse_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
